// File: rtl/cdec8_bus_pkg.sv
// Shared CDEC8 bus definitions: responder FSM encoding, mmrw codes, default addresses and widths.
package cdec8_bus_pkg;

  // Responder sequencing: load program/data, serve the core, then hold results.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } resp_state_e;

  // Core mmrw bus codes.
  localparam logic [1:0] MMRW_WR = 2'b01;
  localparam logic [1:0] MMRW_RD = 2'b10;

  localparam logic [7:0]  DEF_IO_ADDR  = 8'hFF;
  localparam logic [7:0]  PROT_TOP     = 8'h80;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned MEM_ADDR_W   = 8;
  localparam int unsigned MEM_DATA_W   = 8;
  localparam int unsigned MEM_DEPTH    = 256;

  // Last address the loader fills; the top address is the I/O byte.
  localparam logic [7:0]  LD_LAST_ADDR = 8'hFE;

endpackage

// File: rtl/cdec8_ram256.sv
// 256x8 RAM: one synchronous write port, two asynchronous read ports.
// Ports:
//   clk                      clock for the write port
//   i_we/i_waddr/i_wdata     write port, lands on the rising edge
//   i_raddr_a -> o_rdata_a   core read port (combinational)
//   i_raddr_b -> o_rdata_b   readout port (combinational)
module cdec8_ram256
  import cdec8_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [MEM_ADDR_W-1:0] i_waddr,
  input  logic [MEM_DATA_W-1:0] i_wdata,
  input  logic [MEM_ADDR_W-1:0] i_raddr_a,
  output logic [MEM_DATA_W-1:0] o_rdata_a,
  input  logic [MEM_ADDR_W-1:0] i_raddr_b,
  output logic [MEM_DATA_W-1:0] o_rdata_b
);

  logic [MEM_DATA_W-1:0] r_mem [MEM_DEPTH];

  // Contents are deliberately not reset so a reset keeps the loaded image.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/cdec8_mem_responder.sv
// CDEC8 memory-side responder: byte-stream loader, 256-byte RAM with one I/O byte,
// core read/write service, result readout port and completion flag.
// Ports:
//   clock, reset                      clock, synchronous active-high reset
//   ld_valid/ld_data/ld_last/ld_ready loader byte stream (transfer = ld_valid & ld_ready)
//   cpu_run                           core reset_N, high from the first RUN cycle onward
//   adrs/data_in/data_out/mmwr_en     core bus; reads combinational, writes at the edge
//   endseq                            core end-of-sequence, moves to HALT
//   resad -> resdt                    readout port (combinational)
//   io_in/io_out                      I/O byte at IO_ADDR (read returns io_in, write sets io_out)
//   done                              HALT reached
//   wr_count                          saturating count of core writes performed
//   wprot_err                         sticky protected-write flag
// Build option: define CDEC8_MEM_WPROT_EN to drop core writes below PROT_TOP and flag them.
module cdec8_mem_responder
  import cdec8_bus_pkg::*;
#(
  parameter logic [7:0]  IO_ADDR = DEF_IO_ADDR,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld_valid,
  input  logic [7:0]       ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_run,
  input  logic [7:0]       adrs,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  input  logic             mmwr_en,
  input  logic             endseq,
  input  logic [7:0]       resad,
  output logic [7:0]       resdt,
  input  logic [7:0]       io_in,
  output logic [7:0]       io_out,
  output logic             done,
  output logic [CNT_W-1:0] wr_count,
  output logic             wprot_err
);

  resp_state_e      r_state;
  resp_state_e      w_state_nxt;
  logic             r_ld_ready;
  logic             r_cpu_run;
  logic             r_done;
  logic [7:0]       r_ld_ptr;
  logic [7:0]       r_io_out;
  logic [CNT_W-1:0] r_wr_count;

  logic             w_ld_xfer;
  logic             w_core_wr;
  logic             w_is_io;
  logic             w_prot_hit;
  logic             w_core_ok;
  logic             w_ram_we;
  logic [7:0]       w_ram_waddr;
  logic [7:0]       w_ram_wdata;
  logic [7:0]       w_rd_core;
  logic [7:0]       w_rd_res;

  // r_ld_ready is high exactly while in LOAD, so it also qualifies transfers.
  assign w_ld_xfer = ld_valid & r_ld_ready;
  assign w_core_wr = (r_state == ST_RUN) & mmwr_en;
  assign w_is_io   = (adrs == IO_ADDR);

`ifdef CDEC8_MEM_WPROT_EN
  logic r_wprot_err;
  assign w_prot_hit = (adrs < PROT_TOP);

  // Sticky flag for core writes into the protected low region.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wprot_err <= 1'b0;
    end else if (w_core_wr && w_prot_hit) begin
      r_wprot_err <= 1'b1;
    end
  end

  assign wprot_err = r_wprot_err;
`else
  assign w_prot_hit = 1'b0;
  assign wprot_err  = 1'b0;
`endif

  assign w_core_ok = w_core_wr & ~w_prot_hit;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_ld_xfer && (ld_last || (r_ld_ptr == LD_LAST_ADDR))) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (endseq) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_LOAD;
      r_ld_ready <= 1'b1;
      r_cpu_run  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ld_ready <= (w_state_nxt == ST_LOAD);
      r_cpu_run  <= (w_state_nxt != ST_LOAD);
      r_done     <= (w_state_nxt == ST_HALT);
    end
  end

  // RAM write mux: loader owns the port in LOAD, the core in RUN (I/O byte excluded).
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = adrs;
    w_ram_wdata = data_in;
    if (w_ld_xfer) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_ld_ptr;
      w_ram_wdata = ld_data;
    end else if (w_core_ok && !w_is_io) begin
      w_ram_we    = 1'b1;
    end
  end

  // Loader pointer, I/O register and saturating write counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ld_ptr   <= 8'h00;
      r_io_out   <= 8'h00;
      r_wr_count <= '0;
    end else begin
      if (w_ld_xfer) begin
        r_ld_ptr <= r_ld_ptr + 8'(1);
      end
      if (w_core_ok && w_is_io) begin
        r_io_out <= data_in;
      end
      if (w_core_ok && (r_wr_count != {CNT_W{1'b1}})) begin
        r_wr_count <= r_wr_count + CNT_W'(1);
      end
    end
  end

  cdec8_ram256 u_ram (
    .clk       (clock),
    .i_we      (w_ram_we),
    .i_waddr   (w_ram_waddr),
    .i_wdata   (w_ram_wdata),
    .i_raddr_a (adrs),
    .o_rdata_a (w_rd_core),
    .i_raddr_b (resad),
    .o_rdata_b (w_rd_res)
  );

  assign data_out = w_is_io ? io_in : w_rd_core;
  assign resdt    = (resad == IO_ADDR) ? r_io_out : w_rd_res;

  assign ld_ready = r_ld_ready;
  assign cpu_run  = r_cpu_run;
  assign done     = r_done;
  assign io_out   = r_io_out;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_cdec8_mem_responder.sv
// Directed self-checking bench for cdec8_mem_responder.
module tb_cdec8_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_run;
  logic [7:0]  adrs;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        mmwr_en;
  logic        endseq;
  logic [7:0]  resad;
  logic [7:0]  resdt;
  logic [7:0]  io_in;
  logic [7:0]  io_out;
  logic        done;
  logic [15:0] wr_count;
  logic        wprot_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  cdec8_mem_responder dut (
    .clock     (clock),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_run   (cpu_run),
    .adrs      (adrs),
    .data_in   (data_in),
    .data_out  (data_out),
    .mmwr_en   (mmwr_en),
    .endseq    (endseq),
    .resad     (resad),
    .resdt     (resdt),
    .io_in     (io_in),
    .io_out    (io_out),
    .done      (done),
    .wr_count  (wr_count),
    .wprot_err (wprot_err)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    mmwr_en  = 1'b0; data_in = 8'h00; endseq = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    adrs = 8'h00; resad = 8'h00; io_in = 8'h00;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    vectors++;
    if ({ld_ready, cpu_run, done, wprot_err} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags got rdy/run/done/err=%b want 1000", {ld_ready, cpu_run, done, wprot_err});
    end
    vectors++;
    if (io_out !== 8'h00 || wr_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_regs got io_out=%h wr_count=%h want 00/0000", io_out, wr_count);
    end
  endtask

  task automatic test_load3();
    logic [7:0] bytes [3];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = bytes[i]; ld_last = (i == 2);
      tick();
      if (i < 2) begin
        vectors++;
        if (ld_ready !== 1'b1 || cpu_run !== 1'b0) begin
          miscompares++;
          $display("FAIL load3_midload byte%0d got ld_ready=%b cpu_run=%b want 1/0", i, ld_ready, cpu_run);
        end
      end
    end
    idle_inputs();
    vectors++;
    if (ld_ready !== 1'b0 || cpu_run !== 1'b1) begin
      miscompares++;
      $display("FAIL load3_release got ld_ready=%b cpu_run=%b want 0/1", ld_ready, cpu_run);
    end
    for (int i = 0; i < 3; i++) begin
      resad = 8'(i); adrs = 8'(i);
      #1;
      vectors++;
      if (resdt !== bytes[i] || data_out !== bytes[i]) begin
        miscompares++;
        $display("FAIL load3_mem[%0d] got resdt=%h data_out=%h want %h", i, resdt, data_out, bytes[i]);
      end
    end
  endtask

  task automatic test_run_write();
    adrs = 8'h90; data_in = 8'hA5; mmwr_en = 1'b1;
    tick();
    mmwr_en = 1'b0; resad = 8'h90;
    #1;
    vectors++;
    if (data_out !== 8'hA5 || resdt !== 8'hA5 || wr_count !== 16'd1) begin
      miscompares++;
      $display("FAIL run_write got data_out=%h resdt=%h wr_count=%0d want A5/A5/1", data_out, resdt, wr_count);
    end
  endtask

  task automatic test_io();
    io_in = 8'h3C;
    adrs = 8'hFF; data_in = 8'h5A; mmwr_en = 1'b1;
    tick();
    mmwr_en = 1'b0; resad = 8'hFF;
    #1;
    vectors++;
    if (io_out !== 8'h5A || data_out !== 8'h3C || resdt !== 8'h5A) begin
      miscompares++;
      $display("FAIL io_byte got io_out=%h data_out=%h resdt=%h want 5A/3C/5A", io_out, data_out, resdt);
    end
    vectors++;
    if (wr_count !== 16'd2) begin
      miscompares++;
      $display("FAIL io_count got %0d want 2", wr_count);
    end
  endtask

  task automatic test_read_during_write();
    adrs = 8'h90; data_in = 8'h99; mmwr_en = 1'b1;
    #1;
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL rdw_old got %h want A5", data_out);
    end
    tick();
    mmwr_en = 1'b0;
    #1;
    vectors++;
    if (data_out !== 8'h99 || wr_count !== 16'd3) begin
      miscompares++;
      $display("FAIL rdw_new got data_out=%h wr_count=%0d want 99/3", data_out, wr_count);
    end
  endtask

  task automatic test_protect();
    logic [7:0]  exp_data;
    logic [15:0] exp_cnt;
    logic        exp_err;
`ifdef CDEC8_MEM_WPROT_EN
    exp_data = 8'h33; exp_cnt = 16'd3; exp_err = 1'b1;
`else
    exp_data = 8'h44; exp_cnt = 16'd4; exp_err = 1'b0;
`endif
    adrs = 8'h02; data_in = 8'h44; mmwr_en = 1'b1;
    tick();
    mmwr_en = 1'b0; resad = 8'h02;
    #1;
    vectors++;
    if (resdt !== exp_data || wr_count !== exp_cnt || wprot_err !== exp_err) begin
      miscompares++;
      $display("FAIL protect got mem=%h cnt=%0d err=%b want %h/%0d/%b",
               resdt, wr_count, wprot_err, exp_data, exp_cnt, exp_err);
    end
  endtask

  task automatic test_reset_in_run();
    reset = 1'b1;
    tick();
    reset = 1'b0; resad = 8'h90;
    #1;
    vectors++;
    if (cpu_run !== 1'b0 || ld_ready !== 1'b1 || io_out !== 8'h00 || wr_count !== 16'd0 || wprot_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_run got run=%b rdy=%b io_out=%h cnt=%0d err=%b want 0/1/00/0/0",
               cpu_run, ld_ready, io_out, wr_count, wprot_err);
    end
    vectors++;
    if (resdt !== 8'h99) begin
      miscompares++;
      $display("FAIL reset_keeps_ram got %h want 99", resdt);
    end
  endtask

  task automatic test_load_full();
    int early_release = 0;
    for (int i = 0; i < 255; i++) begin
      ld_valid = 1'b1; ld_last = 1'b0; ld_data = 8'(i) ^ 8'h5A;
      tick();
      if (i < 254 && ld_ready !== 1'b1) early_release++;
    end
    vectors++;
    if (early_release != 0) begin
      miscompares++;
      $display("FAIL load_full_early got %0d early releases want 0", early_release);
    end
    vectors++;
    if (ld_ready !== 1'b0 || cpu_run !== 1'b1) begin
      miscompares++;
      $display("FAIL load_full_release got rdy=%b run=%b want 0/1", ld_ready, cpu_run);
    end
    // 256th byte offered: must not be accepted and must not disturb RAM.
    ld_data = 8'hEE;
    tick();
    idle_inputs();
    vectors++;
    if (ld_ready !== 1'b0 || cpu_run !== 1'b1 || wr_count !== 16'd0) begin
      miscompares++;
      $display("FAIL load_full_extra got rdy=%b run=%b cnt=%0d want 0/1/0", ld_ready, cpu_run, wr_count);
    end
    resad = 8'h00; #1;
    vectors++;
    if (resdt !== 8'h5A) begin
      miscompares++;
      $display("FAIL load_full_mem00 got %h want 5A", resdt);
    end
    resad = 8'h7F; #1;
    vectors++;
    if (resdt !== 8'h25) begin
      miscompares++;
      $display("FAIL load_full_mem7F got %h want 25", resdt);
    end
    resad = 8'hFE; #1;
    vectors++;
    if (resdt !== 8'hA4) begin
      miscompares++;
      $display("FAIL load_full_memFE got %h want A4", resdt);
    end
  endtask

  task automatic test_endseq();
    adrs = 8'h90; data_in = 8'hC3; mmwr_en = 1'b1; endseq = 1'b1;
    tick();
    idle_inputs(); resad = 8'h90;
    #1;
    vectors++;
    if (done !== 1'b1 || cpu_run !== 1'b1 || resdt !== 8'hC3 || wr_count !== 16'd1) begin
      miscompares++;
      $display("FAIL endseq_write got done=%b run=%b mem=%h cnt=%0d want 1/1/C3/1",
               done, cpu_run, resdt, wr_count);
    end
    mmwr_en = 1'b1; data_in = 8'hEE; ld_valid = 1'b1; ld_data = 8'h77;
    tick();
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (done !== 1'b1 || resdt !== 8'hC3 || wr_count !== 16'd1 || ld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_frozen got done=%b mem=%h cnt=%0d rdy=%b want 1/C3/1/0",
               done, resdt, wr_count, ld_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load3();
    test_run_write();
    test_io();
    test_read_during_write();
    test_protect();
    test_reset_in_run();
    test_load_full();
    test_endseq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
